// File: rtl/mem_responder.sv
// Data-memory responder: word RAM with byte/half/word access, fixed response latency,
// and fault reporting (out-of-range, misaligned, illegal size, conflicting request).
module mem_responder #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  func3,
  output logic [31:0] rdata,
  output logic        mem_rvalid,
  output logic        mem_finish,
  output logic        busy,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = 33'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        load;
  logic        rd_reg, wr_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic [2:0]  func3_reg;

  logic [31:0] ram [DEPTH];
  logic [31:0] ram_q;
  logic [32:0] off;
  logic [AW-1:0] idx;
  logic        out_of_range, misaligned, bad_func3, fault;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic        we;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] rext;
  logic        rd_ok;

  // Fault decode works on the latched request, so it is stable through WAIT and RESP.
  assign off          = {1'b0, addr_reg} - {1'b0, BASE};
  assign idx          = off[AW+1:2];
  assign out_of_range = (off >= LIMIT);
  assign bad_func3    = (func3_reg == 3'b011) || (func3_reg[2:1] == 2'b11);
  assign misaligned   = ((func3_reg[1:0] == 2'b01) && addr_reg[0]) ||
                        ((func3_reg[1:0] == 2'b10) && (addr_reg[1:0] != 2'b00));
  assign fault        = (rd_reg && wr_reg) || out_of_range || bad_func3 || misaligned;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rd_reg    <= 1'b0;
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      func3_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (load) begin
        rd_reg    <= mem_read;
        wr_reg    <= mem_write;
        addr_reg  <= addr;
        wdata_reg <= wdata;
        func3_reg <= func3;
      end
    end
  end

  // The counter always passes through WAIT, giving exactly LATENCY edges to RESP;
  // the edge that ends RESP may accept the next request.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: if (mem_read || mem_write) begin
        load       = 1'b1;
        cnt_next   = 4'(LATENCY - 1);
        state_next = WAIT;
      end
      WAIT: if (cnt_reg == 4'd0) state_next = RESP;
            else cnt_next = cnt_reg - 4'd1;
      RESP: if (mem_read || mem_write) begin
        load       = 1'b1;
        cnt_next   = 4'(LATENCY - 1);
        state_next = WAIT;
      end else begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wlane[gi*8 +: 8] = (func3_reg[1:0] == 2'b00) ? wdata_reg[7:0] :
                                (func3_reg[1:0] == 2'b01) ? wdata_reg[(gi%2)*8 +: 8] :
                                                            wdata_reg[gi*8 +: 8];
      assign be[gi] = (func3_reg[1:0] == 2'b00) ? (addr_reg[1:0] == 2'(gi)) :
                      (func3_reg[1:0] == 2'b01) ? (addr_reg[1] == 1'(gi / 2)) :
                                                  1'b1;
    end
  endgenerate

  assign we = (state_reg == WAIT) && (cnt_reg == 4'd0) && wr_reg && !fault;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[idx][i*8 +: 8] <= wlane[i*8 +: 8];
      end
    end
    ram_q <= ram[idx];
  end

  assign rbyte = ram_q[{addr_reg[1:0], 3'b000} +: 8];
  assign rhalf = addr_reg[1] ? ram_q[31:16] : ram_q[15:0];

  always_comb begin
    rext = '0;
    case (func3_reg)
      3'b000:  rext = {{24{rbyte[7]}}, rbyte};
      3'b001:  rext = {{16{rhalf[15]}}, rhalf};
      3'b010:  rext = ram_q;
      3'b100:  rext = {24'd0, rbyte};
      3'b101:  rext = {16'd0, rhalf};
      default: rext = '0;
    endcase
  end

  // A conflicting read+write is not a read, so it finishes without rvalid.
  assign mem_finish = (state_reg == RESP);
  assign mem_rvalid = mem_finish && rd_reg && !wr_reg;
  assign err        = mem_finish && fault;
  assign rd_ok      = mem_rvalid && !fault;
  assign rdata      = rd_ok ? rext : 32'd0;
  assign busy       = (state_reg == WAIT);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (LATENCY=2): reset, word/sub-word round trips,
// faults, busy/back-to-back behaviour and reset during a pending write.
module tb_mem_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic [2:0]  func3;
  logic [31:0] rdata;
  logic        mem_rvalid, mem_finish, busy, err;

  int n_cmp = 0;
  int n_err = 0;
  int fin;

  always #5 clk = ~clk;

  mem_responder #(.BASE(32'h8000_0000), .DEPTH(1024), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .func3(func3), .rdata(rdata),
    .mem_rvalid(mem_rvalid), .mem_finish(mem_finish), .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and check every cycle up to one past RESP.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                        input logic [31:0] exp_rdata, input logic exp_rvalid, input logic exp_err);
    mem_read = rd; mem_write = wr; addr = a; wdata = wd; func3 = f3;
    step();
    mem_read = 0; mem_write = 0; addr = '0; wdata = '0; func3 = '0;
    for (int i = 1; i < LAT; i++) begin
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_early_fin"}, mem_finish, 0);
      step();
    end
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_early_fin"}, mem_finish, 0);
    step();
    chk({tag, "_fin"}, mem_finish, 1);
    chk({tag, "_rvalid"}, mem_rvalid, exp_rvalid);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_rdata"}, rdata, exp_rdata);
    chk({tag, "_resp_busy"}, busy, 0);
    $display("%s: addr=%h rdata=%h rvalid=%0d err=%0d", tag, a, rdata, mem_rvalid, err);
    step();
    chk({tag, "_fin_drop"}, mem_finish, 0);
    chk({tag, "_rvalid_drop"}, mem_rvalid, 0);
    chk({tag, "_rdata_zero"}, rdata, 0);
  endtask

  initial begin
    rst = 0; mem_read = 1; mem_write = 0; addr = 32'h8000_0010; wdata = 0; func3 = 3'b010;
    repeat (3) step();
    chk("rst_fin", mem_finish, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rvalid", mem_rvalid, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    mem_read = 0;
    rst = 1;
    step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_fin", mem_finish, 0);
    $display("reset: busy=%0d finish=%0d", busy, mem_finish);

    access("sw",   0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 3'b010, 32'h0, 0, 0);
    access("lw",   1, 0, 32'h8000_0010, 32'h0,         3'b010, 32'hDEAD_BEEF, 1, 0);
    access("sb",   0, 1, 32'h8000_0011, 32'hAAAA_AA7F, 3'b000, 32'h0, 0, 0);
    access("lw_sb",1, 0, 32'h8000_0010, 32'h0,         3'b010, 32'hDEAD_7FEF, 1, 0);
    access("lb",   1, 0, 32'h8000_0013, 32'h0,         3'b000, 32'hFFFF_FFDE, 1, 0);
    access("lbu",  1, 0, 32'h8000_0013, 32'h0,         3'b100, 32'h0000_00DE, 1, 0);
    access("lh",   1, 0, 32'h8000_0012, 32'h0,         3'b001, 32'hFFFF_DEAD, 1, 0);
    access("lhu",  1, 0, 32'h8000_0010, 32'h0,         3'b101, 32'h0000_7FEF, 1, 0);
    access("sh",   0, 1, 32'h8000_0012, 32'h1234_8001, 3'b001, 32'h0, 0, 0);
    access("lh_sh",1, 0, 32'h8000_0012, 32'h0,         3'b001, 32'hFFFF_8001, 1, 0);
    access("lw_sh",1, 0, 32'h8000_0010, 32'h0,         3'b010, 32'h8001_7FEF, 1, 0);

    access("lw_mis",  1, 0, 32'h8000_0002, 32'h0, 3'b010, 32'h0, 1, 1);
    access("lh_mis",  1, 0, 32'h8000_0011, 32'h0, 3'b001, 32'h0, 1, 1);
    access("sw_top",  0, 1, 32'h8000_0FFC, 32'h0BAD_F00D, 3'b010, 32'h0, 0, 0);
    access("sw_low",  0, 1, 32'h7FFF_FFFC, 32'h5555_5555, 3'b010, 32'h0, 0, 1);
    access("lw_top",  1, 0, 32'h8000_0FFC, 32'h0, 3'b010, 32'h0BAD_F00D, 1, 0);
    access("lw_oob",  1, 0, 32'h8000_1000, 32'h0, 3'b010, 32'h0, 1, 1);
    access("both",    1, 1, 32'h8000_0010, 32'h0, 3'b010, 32'h0, 0, 1);
    access("ill_f3",  1, 0, 32'h8000_0010, 32'h0, 3'b011, 32'h0, 1, 1);
    access("lw_keep", 1, 0, 32'h8000_0010, 32'h0, 3'b010, 32'h8001_7FEF, 1, 0);

    // Second pulse while busy must be dropped.
    mem_read = 1; addr = 32'h8000_0010; func3 = 3'b010;
    step();
    step();
    mem_read = 0;
    fin = 0;
    repeat (8) begin
      step();
      if (mem_finish) fin++;
    end
    chk("busy_ignore_count", fin, 1);
    $display("busy_ignore: finishes=%0d", fin);

    // Back-to-back: request presented during RESP is accepted at the edge ending it.
    mem_read = 1; addr = 32'h8000_0010; func3 = 3'b010;
    step();
    mem_read = 0;
    step();
    step();
    chk("b2b_first_fin", mem_finish, 1);
    chk("b2b_first_rdata", rdata, 32'h8001_7FEF);
    mem_read = 1; addr = 32'h8000_0FFC; func3 = 3'b010;
    step();
    mem_read = 0;
    chk("b2b_accept_busy", busy, 1);
    chk("b2b_gap_fin", mem_finish, 0);
    step();
    step();
    chk("b2b_second_fin", mem_finish, 1);
    chk("b2b_second_rdata", rdata, 32'h0BAD_F00D);
    $display("b2b: rdata=%h", rdata);
    step();

    // Reset during a pending write drops it.
    access("sw_prior", 0, 1, 32'h8000_0020, 32'hCAFE_BABE, 3'b010, 32'h0, 0, 0);
    mem_write = 1; addr = 32'h8000_0020; wdata = 32'h1234_5678; func3 = 3'b010;
    step();
    mem_write = 0;
    rst = 0;
    #1;
    chk("midrst_busy", busy, 0);
    fin = 0;
    step();
    step();
    if (mem_finish) fin++;
    rst = 1;
    repeat (4) begin
      step();
      if (mem_finish) fin++;
    end
    chk("midrst_no_fin", fin, 0);
    $display("midrst: finishes=%0d", fin);
    access("lw_after_rst", 1, 0, 32'h8000_0020, 32'h0, 3'b010, 32'hCAFE_BABE, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
